// File: rtl/cpu_pkg.sv
// Shared constants for the fetch front end: fetch FSM state encoding,
// instruction memory depth and the program counter start address.
// No ports; imported by fetch_sequencer and its helpers.
package cpu_pkg;

  localparam int          IMEM_DEPTH = 128;
  localparam logic [15:0] RESET_PC   = 16'h0000;

  // Fetch FSM encoding, also visible to software through state_o.
  localparam logic [1:0] FS_IDLE = 2'd0;
  localparam logic [1:0] FS_LOAD = 2'd1;
  localparam logic [1:0] FS_RUN  = 2'd2;
  localparam logic [1:0] FS_HALT = 2'd3;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Two 16-bit saturating event counters for the fetch stage: decoded-instruction
// handshakes (fetch_i) and decode-stall cycles (stall_i). clr_i zeroes both.
// Ports: clk, rst (async active-low), clr_i, fetch_i, stall_i, perf_fetch_o, perf_stall_o.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        fetch_i,
  input  logic        stall_i,
  output logic [15:0] perf_fetch_o,
  output logic [15:0] perf_stall_o
);

  logic [15:0] fetch_q;
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_q <= 16'h0000;
      stall_q <= 16'h0000;
    end else if (clr_i) begin
      fetch_q <= 16'h0000;
      stall_q <= 16'h0000;
    end else begin
      if (fetch_i && (fetch_q != 16'hFFFF)) fetch_q <= fetch_q + 16'd1;
      if (stall_i && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
    end
  end

  assign perf_fetch_o = fetch_q;
  assign perf_stall_o = stall_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, drives the instruction memory read
// address, hands one registered instruction per handshake to decode, redirects on
// branches and lets a host loader write the memory while fetch is stopped.
// Ports: clk/rst (async active-low); start/halt_req control; ld_* loader port;
// imem_* memory ports; if_*/id_ready decode handshake; br_* redirect; state_o, fault.
// Optional FETCH_PERF_EN macro adds perf_fetch/perf_stall counter outputs.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = IMEM_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt_req,
  input  logic               ld_valid,
  input  logic               ld_last,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [INSTR_W-1:0] ld_data,
  output logic               ld_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_waddr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic [1:0]         state_o,
  output logic               fault
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        perf_fetch,
  output logic [15:0]        perf_stall
`endif
);

  // One extra bit so the range checks also work when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(DEPTH - 1);

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               if_valid_q, if_valid_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
  logic               fault_q, fault_d;

  logic stopped;
  logic start_go;
  logic br_fault;
  logic end_fault;

  assign stopped   = (state_q == FS_IDLE) || (state_q == FS_HALT);
  // A loader word wins over start when both arrive while stopped.
  assign start_go  = stopped && !ld_valid && start;
  assign br_fault  = {1'b0, br_target} >= DEPTH_X;
  // Fetching the last valid word means the next PC would leave the memory.
  assign end_fault = pc_q >= LAST_PC;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    fault_d    = fault_q;

    case (state_q)
      FS_IDLE, FS_HALT: begin
        // A word delivered just before a fault halt may still be pending; let decode drain it.
        if (if_valid_q && id_ready) if_valid_d = 1'b0;
        if (ld_valid) begin
          state_d    = FS_LOAD;
          if_valid_d = 1'b0;
        end else if (start) begin
          state_d    = FS_RUN;
          pc_d       = RESET_PC;
          fault_d    = 1'b0;
          if_valid_d = 1'b0;
        end
      end
      FS_LOAD: begin
        if (ld_valid && ld_last) state_d = FS_IDLE;
      end
      default: begin // FS_RUN
        if (halt_req) begin
          state_d    = FS_HALT;
          if_valid_d = 1'b0;
        end else if (br_taken) begin
          if_valid_d = 1'b0;
          if (br_fault) begin
            // Out-of-range target is never loaded so imem_addr stays inside the memory.
            fault_d = 1'b1;
            state_d = FS_HALT;
          end else begin
            pc_d = br_target;
          end
        end else if (!if_valid_q || id_ready) begin
          if_instr_d = imem_instr;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          if (end_fault) begin
            fault_d = 1'b1;
            state_d = FS_HALT;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FS_IDLE;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      fault_q    <= fault_d;
    end
  end

  // Loader words are always accepted in LOAD; out-of-range ones are simply not written.
  assign ld_ready   = (state_q == FS_LOAD) && ld_valid;
  assign imem_we    = ld_ready && ({1'b0, ld_addr} < DEPTH_X);
  assign imem_waddr = ld_addr;
  assign imem_wdata = ld_data;

  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign state_o   = state_q;
  assign fault     = fault_q;

`ifdef FETCH_PERF_EN
  fetch_perf_cnt u_perf (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (start_go),
    .fetch_i      (if_valid_q && id_ready),
    .stall_i      ((state_q == FS_RUN) && if_valid_q && !id_ready),
    .perf_fetch_o (perf_fetch),
    .perf_stall_o (perf_stall)
  );
`endif

endmodule
